// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared types and helpers for the write-back trace buffer.
//   trace_state_t      : capture FSM states (IDLE, ARMED, CAPTURE)
//   WB_TRACE_DEPTH_DEF : default FIFO depth
//   sig_next()         : one step of the rotate-left-by-1 / XOR signature,
//                        computed on a 64-bit carrier so any DATA_W <= 64 works.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } trace_state_t;

  localparam int WB_TRACE_DEPTH_DEF = 16;
  localparam int SIG_MAX_W          = 64;

  // sig and data must be zero above bit w-1; the result is too.
  function automatic logic [SIG_MAX_W-1:0] sig_next(
    input logic [SIG_MAX_W-1:0] sig,
    input logic [SIG_MAX_W-1:0] data,
    input int unsigned          w
  );
    logic [SIG_MAX_W-1:0] mask;
    logic [SIG_MAX_W-1:0] rot;
    mask = (w >= SIG_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    rot  = ((sig << 1) | (sig >> (w - 1))) & mask;
    return rot ^ data;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: DEPTH x DATA_W show-ahead FIFO.
//   clk, reset   : clock, synchronous active-high reset
//   push/push_data : write request (dropped internally if full and no pop)
//   pop_req      : consumer ready; a pop happens only when non-empty
//   rd_valid     : non-empty
//   rd_data      : mem[rd_ptr], forced to 0 while empty
//   count        : occupancy 0..DEPTH
//   full         : count == DEPTH
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign rd_valid = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop_req && rd_valid;
  // A full FIFO can still take a word when a pop frees a slot the same edge.
  assign do_push  = push && (!full || do_pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Storage needs no reset: count/pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: write-back trace capture.
//   Taps the core write-back stream (wb_valid/WB_Data). An arm/trigger/stop
//   FSM gates capture into a show-ahead FIFO drained via rd_valid/rd_ready.
//   Ports: clk, reset (sync, active high), wb_valid, WB_Data, arm, stop,
//   trig_val, rd_ready -> rd_valid, rd_data, count, overflow (sticky),
//   capturing, signature.
//   Build option WB_TRACE_SIG_EN: when defined, a rotate-XOR signature of
//   accepted pushes is kept; otherwise signature is tied to 0.
//   DATA_W must be <= 64 (signature helper width).
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH  = WB_TRACE_DEPTH_DEF,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              arm,
  input  logic              stop,
  input  logic [DATA_W-1:0] trig_val,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              capturing,
  output logic [DATA_W-1:0] signature
);

  trace_state_t state;
  logic         arm_go, trig_hit, push_req, pop, full, drop, push_ok;

  assign arm_go   = (state == IDLE) && arm;
  // stop beats a same-cycle trigger match
  assign trig_hit = (state == ARMED) && wb_valid && (WB_Data == trig_val) && !stop;
  // in CAPTURE a word coincident with stop is still taken
  assign push_req = trig_hit || ((state == CAPTURE) && wb_valid);
  assign pop      = rd_valid && rd_ready;
  assign drop     = push_req && full && !pop;
  assign push_ok  = push_req && !drop;

  wb_trace_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_ok),
    .push_data (WB_Data),
    .pop_req   (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      capturing <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) state <= ARMED;
        end
        ARMED: begin
          if (stop) begin
            state     <= IDLE;
            capturing <= 1'b0;
          end else if (trig_hit) begin
            state     <= CAPTURE;
            capturing <= 1'b1;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state     <= IDLE;
            capturing <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          capturing <= 1'b0;
        end
      endcase
      // arm only lands in IDLE where no push can occur, so no conflict
      if (arm_go)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

`ifdef WB_TRACE_SIG_EN
  logic [DATA_W-1:0]    sig_q;
  logic [SIG_MAX_W-1:0] sig64, dat64, nxt64;
  logic                 sig_unused;

  always_comb begin
    sig64 = '0;
    dat64 = '0;
    sig64[DATA_W-1:0] = sig_q;
    dat64[DATA_W-1:0] = WB_Data;
    nxt64 = sig_next(sig64, dat64, DATA_W);
  end

  // upper carrier bits are always zero
  assign sig_unused = ^nxt64;

  always_ff @(posedge clk) begin
    if (reset || arm_go) sig_q <= '0;
    else if (push_ok)    sig_q <= nxt64[DATA_W-1:0];
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer (DEPTH=4). Stimulus pushes the words
// it expects to read back into exp_q; a forked monitor compares rd_data at
// every negedge where a pop is presented.
module tb_wb_trace_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, reset, wb_valid, arm, stop, rd_ready;
  logic [DW-1:0] WB_Data, trig_val, rd_data, signature;
  logic          rd_valid, overflow, capturing;
  logic [CW-1:0] count;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];

  wb_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .WB_Data(WB_Data),
    .arm(arm), .stop(stop), .trig_val(trig_val), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .overflow(overflow), .capturing(capturing), .signature(signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    wb_valid = 1'b1;
    WB_Data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [DW-1:0] t);
    trig_val = t;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain(input string name);
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && count != 0; i++) tick();
    rd_ready = 1'b0;
    check({name, "_count"}, DW'(count), 0);
    check({name, "_sb_left"}, DW'(exp_q.size()), 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_data: got %h want nothing (scoreboard empty)", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; WB_Data = '0; arm = 1'b0; stop = 1'b0;
    trig_val = '0; rd_ready = 1'b0;
    fork monitor(); join_none
    tick(); tick();
    reset = 1'b0;
    check("rst_count",     DW'(count), 0);
    check("rst_rd_valid",  DW'(rd_valid), 0);
    check("rst_rd_data",   rd_data, 0);
    check("rst_overflow",  DW'(overflow), 0);
    check("rst_capturing", DW'(capturing), 0);
    check("rst_signature", signature, 0);

    // trigger: 0x5 ignored, capture starts at 0x10
    do_arm(32'h10);
    check("armed_not_capturing", DW'(capturing), 0);
    put(32'h5);
    check("pre_trig_count", DW'(count), 0);
    put(32'h10); exp_q.push_back(32'h10);
    check("trig_capturing", DW'(capturing), 1);
    check("trig_rd_valid",  DW'(rd_valid), 1);
    check("trig_rd_data",   rd_data, 32'h10);
    put(32'h20); exp_q.push_back(32'h20);
    put(32'h30); exp_q.push_back(32'h30);
    check("trig_count", DW'(count), 3);
    do_stop();
    check("stop_capturing", DW'(capturing), 0);
    drain("trig_drain");

    // overflow: 6 words into a 4-deep FIFO, last two dropped
    do_arm(32'h1);
    for (int i = 1; i <= 6; i++) begin
      put(DW'(i));
      if (i <= 4) exp_q.push_back(DW'(i));
    end
    check("ovf_count", DW'(count), 4);
    check("ovf_flag",  DW'(overflow), 1);
    do_stop();
    drain("ovf_drain");
    check("ovf_sticky", DW'(overflow), 1);

    // full + simultaneous push/pop
    do_arm(32'h1);
    check("arm_clears_ovf", DW'(overflow), 0);
    for (int i = 1; i <= 4; i++) begin
      put(DW'(i));
      exp_q.push_back(DW'(i));
    end
    check("full_count", DW'(count), 4);
    rd_ready = 1'b1;
    exp_q.push_back(32'hAA);
    put(32'hAA);
    rd_ready = 1'b0;
    check("full_pp_count", DW'(count), 4);
    check("full_pp_ovf",   DW'(overflow), 0);
    do_stop();
    drain("full_drain");

    // signature over 1,2,4: 0->1; rotl(1)^2=0; rotl(0)^4=4
    do_arm(32'h1);
    check("arm_clears_sig", signature, 0);
    put(32'h1); exp_q.push_back(32'h1);
    put(32'h2); exp_q.push_back(32'h2);
    put(32'h4); exp_q.push_back(32'h4);
`ifdef WB_TRACE_SIG_EN
    check("signature", signature, 32'h4);
`else
    check("signature_off", signature, 0);
`endif
    do_stop();
    drain("sig_drain");

    // stop wins over a same-cycle trigger match
    do_arm(32'h55);
    stop = 1'b1; wb_valid = 1'b1; WB_Data = 32'h55;
    tick();
    stop = 1'b0; wb_valid = 1'b0;
    check("stopwin_count",     DW'(count), 0);
    check("stopwin_capturing", DW'(capturing), 0);
    put(32'h55);
    check("stopwin_idle_count", DW'(count), 0);

    // reset mid-capture
    do_arm(32'h7);
    for (int i = 7; i <= 11; i++) put(DW'(i));
    check("midcap_capturing", DW'(capturing), 1);
    check("midcap_count",     DW'(count), 4);
    check("midcap_ovf",       DW'(overflow), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("rst2_count",     DW'(count), 0);
    check("rst2_rd_valid",  DW'(rd_valid), 0);
    check("rst2_capturing", DW'(capturing), 0);
    check("rst2_signature", signature, 0);
    check("rst2_overflow",  DW'(overflow), 0);
    put(32'h7);
    check("rst2_idle_count", DW'(count), 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
